// File: rtl/hamming_pkg.sv
// hamming_pkg: shared widths, data positions, parity masks and FSM states for the Hamming(7,4) decoder
package hamming_pkg;
    localparam int CODE_W = 7;
    localparam int DATA_W = 4;
    localparam int D1_POS = 3;
    localparam int D2_POS = 5;
    localparam int D3_POS = 6;
    localparam int D4_POS = 7;
    localparam logic [CODE_W-1:0] S1_MASK = 7'b1010101;
    localparam logic [CODE_W-1:0] S2_MASK = 7'b1100110;
    localparam logic [CODE_W-1:0] S4_MASK = 7'b1111000;
    typedef enum logic [2:0] {IDLE, LOAD, CHECK, SHIFT, DONE} state_t;
endpackage

// File: rtl/hamming74_serial_decoder_if.sv
// hamming74_serial_decoder_if: serial codeword in, corrected data burst and status out
interface hamming74_serial_decoder_if #(parameter int ERR_CNT_W = 8);
    logic start;
    logic in_valid;
    logic serial_in;
    logic data_out;
    logic out_valid;
    logic busy;
    logic done;
    logic error_flag;
    logic [2:0] syndrome;
    logic [ERR_CNT_W-1:0] err_count;
    modport master(output start, in_valid, serial_in,
                   input data_out, out_valid, busy, done, error_flag, syndrome, err_count);
    modport slave(input start, in_valid, serial_in,
                  output data_out, out_valid, busy, done, error_flag, syndrome, err_count);
endinterface

// File: rtl/hamming74_corrector.sv
// hamming74_corrector: syndrome, single-bit correction and data extraction for one codeword (bit i-1 holds c_i)
module hamming74_corrector
    import hamming_pkg::*;
(
    input  logic [CODE_W-1:0] i_word,
    output logic [2:0]        o_syndrome,
    output logic [DATA_W-1:0] o_data,
    output logic              o_error
);
    logic [CODE_W-1:0] w_fixed;
    // nonzero syndrome is the 1-based position of the flipped bit; d1 lands in o_data[0]
    always_comb begin
        o_syndrome = {^(i_word & S4_MASK), ^(i_word & S2_MASK), ^(i_word & S1_MASK)};
        o_error    = |o_syndrome;
        w_fixed    = i_word ^ (o_error ? CODE_W'(1) << (o_syndrome - 3'd1) : '0);
        o_data     = {w_fixed[D4_POS-1], w_fixed[D3_POS-1], w_fixed[D2_POS-1], w_fixed[D1_POS-1]};
    end
endmodule

// File: rtl/hamming74_serial_decoder.sv
// hamming74_serial_decoder: serial Hamming(7,4) receiver; HAMMING_DEC_ERR_CNT_EN enables the saturating corrected-error counter
module hamming74_serial_decoder
    import hamming_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input logic clk,
    input logic reset,
    hamming74_serial_decoder_if.slave bus
);
    state_t r_state, w_next;
    logic [CODE_W-1:0] r_word;
    logic [2:0] r_cnt;
    logic [DATA_W-1:0] r_sh;
    logic r_out_valid, r_busy, r_done, r_err;
    logic [2:0] r_syn;
    logic [2:0] w_syn;
    logic [DATA_W-1:0] w_data;
    logic w_err;

    hamming74_corrector u_corr (
        .i_word(r_word),
        .o_syndrome(w_syn),
        .o_data(w_data),
        .o_error(w_err)
    );

    // state register
    always_ff @(posedge clk or posedge reset)
        if (reset) r_state <= IDLE;
        else r_state <= w_next;

    // next state: one word per start, bit count and shift count share r_cnt
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = bus.start ? LOAD : IDLE;
            LOAD:    w_next = (bus.in_valid && r_cnt == 3'(CODE_W-1)) ? CHECK : LOAD;
            CHECK:   w_next = SHIFT;
            SHIFT:   w_next = (r_cnt == 3'(DATA_W-1)) ? DONE : SHIFT;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // datapath; status flags are registered from the next state so they line up with it
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_word      <= '0;
            r_cnt       <= '0;
            r_sh        <= '0;
            r_syn       <= '0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_busy      <= w_next != IDLE;
            r_out_valid <= w_next == SHIFT;
            r_done      <= w_next == DONE;
            case (r_state)
                IDLE: r_cnt <= '0;
                LOAD: if (bus.in_valid) begin
                    r_word <= {bus.serial_in, r_word[CODE_W-1:1]};
                    r_cnt  <= r_cnt + 3'd1;
                end
                CHECK: begin
                    r_syn <= w_syn;
                    r_err <= w_err;
                    r_sh  <= w_data;
                    r_cnt <= '0;
                end
                SHIFT: begin
                    r_sh  <= r_sh >> 1;
                    r_cnt <= r_cnt + 3'd1;
                end
                default: ;
            endcase
        end

`ifdef HAMMING_DEC_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] r_err_cnt;
    // saturating count of words that needed correction
    always_ff @(posedge clk or posedge reset)
        if (reset) r_err_cnt <= '0;
        else if (r_state == CHECK && w_err && !(&r_err_cnt)) r_err_cnt <= r_err_cnt + 1'b1;
    assign bus.err_count = r_err_cnt;
`else
    assign bus.err_count = {ERR_CNT_W{1'b0}};
`endif

    assign bus.data_out   = r_sh[0];
    assign bus.out_valid  = r_out_valid;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.error_flag = r_err;
    assign bus.syndrome   = r_syn;
endmodule

// File: doc/hamming74_serial_decoder.md
# hamming74_serial_decoder

Serial Hamming(7,4) receive stage. Deserializes one 7-bit codeword, computes the 3-bit syndrome, corrects any single-bit error, then shifts the 4 corrected data bits out serially in a fixed 4-cycle burst. The shift-enable counter stage downstream consumes this burst. Used once per codeword; the block is idle between words.

## Interface
- ERR_CNT_W, 8, width of the saturating corrected-error counter (used only with the macro in Configuration).
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  one-cycle pulse; begins a codeword while IDLE
- in_valid  in  1  qualifies serial_in during LOAD
- serial_in  in  1  received codeword bit, position 1 first
- data_out  out  1  corrected data bit, valid when out_valid=1
- out_valid  out  1  high for exactly 4 consecutive cycles per codeword
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last data bit
- error_flag  out  1  syndrome nonzero for the last codeword
- syndrome  out  3  last syndrome {s4,s2,s1}
- err_count  out  ERR_CNT_W  corrected-error total (see Configuration)

## Operation
- Codeword positions c1..c7 are p1 p2 d1 p4 d2 d3 d4. The first bit received is c1.
- Syndrome bits:
  - s1 = c1^c3^c5^c7
  - s2 = c2^c3^c6^c7
  - s4 = c4^c5^c6^c7
- A nonzero syndrome is the 1-based position of the flipped bit. That bit is inverted before data extraction. A parity-position error sets error_flag but leaves the data unchanged.
- Output order is d1, d2, d3, d4 (corrected c3, c5, c6, c7).
- FSM states and transitions:
  - IDLE: start=1 goes to LOAD and clears the bit counter. All other inputs are ignored.
  - LOAD: each cycle with in_valid=1 shifts serial_in into the 7-bit register and increments the 3-bit counter. When the 7th bit is captured, go to CHECK. in_valid=0 holds state and counter.
  - CHECK (1 cycle): register syndrome, error_flag and the 4 corrected data bits into the output shift register, then go to SHIFT.
  - SHIFT (4 cycles): out_valid=1, data_out = current head bit, shift once per cycle. After the 4th bit, go to DONE.
  - DONE (1 cycle): done=1, then go to IDLE.
- start outside IDLE is ignored. A start arriving in DONE is also ignored.
- syndrome and error_flag hold their last value until the next CHECK.
- Reset values: all outputs 0, state IDLE, counters 0. Reset asserted mid-word aborts immediately; no partial output and no done pulse.

## Timing
- All outputs are registered.
- start sampled at edge E: LOAD from E+1. The first in_valid bit can be sampled at edge E+1.
- 7th bit sampled at edge T: CHECK during cycle T..T+1. syndrome and error_flag are valid after T+1.
- out_valid is high on cycles T+1..T+5. done is high on cycle T+5..T+6.
- busy is high from E to T+6.
- Minimum start-to-start spacing is 14 cycles (1 + 7 + 1 + 4 + 1).

## Configuration
- HAMMING_DEC_ERR_CNT_EN defined:
  - err_count increments by 1 in each CHECK with a nonzero syndrome.
  - It saturates at 2^ERR_CNT_W−1 and clears only on reset.
- Macro undefined: err_count is a constant 0, with no counter logic. The port remains present for interface stability.

## Structure
- Shared package hamming_pkg holds:
  - CODE_W=7 and DATA_W=4
  - the FSM state enum (IDLE, LOAD, CHECK, SHIFT, DONE)
  - data-position constants (3, 5, 6, 7)
- Sub-module hamming74_corrector (combinational) takes the 7-bit word and returns the syndrome, the corrected 4 data bits and the error flag. The top level holds the FSM, the counters and the shift registers.

## Test plan
- Clean word: data 1011, serial 0,1,1,0,0,1,1 (c1..c7) -> data_out 1,0,1,1 over 4 out_valid cycles; syndrome=000, error_flag=0, one done pulse.
- Data error: same word with c5 flipped (0110111) -> syndrome=101, error_flag=1, data_out 1,0,1,1.
- Parity error: c1 flipped (1110011) -> syndrome=001, error_flag=1, data_out 1,0,1,1.
- Gapped input: in_valid low for 3 cycles between bits 4 and 5 -> output unchanged; out_valid starts 1 cycle after the 7th valid bit.
- Reset mid-LOAD after 4 bits -> all outputs 0, IDLE, no done. A following clean word decodes correctly. A start during SHIFT is ignored.
- With HAMMING_DEC_ERR_CNT_EN and ERR_CNT_W=2: 5 erroneous words -> err_count 1,2,3,3,3. Without the macro -> err_count stays 0.
